// File: rtl/inst_fetch_bridge.sv
// Byte-wide instruction memory to 32-bit fetch bridge: four big-endian beats per word with timeout.
// Optional last-hit word cache enabled by defining BRIDGE_LAST_HIT_EN.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif

module inst_fetch_bridge (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rom_enable,
    input  logic [`INST_ADDR_WIDTH-1:0] rom_addr_in,
    output logic [`INST_DATA_WIDTH-1:0] rom_data_out,
    output logic                        inst_valid,
    output logic                        fetch_stall,
    output logic                        fetch_err,
    output logic                        mem_req,
    output logic [`INST_ADDR_WIDTH-1:0] mem_addr,
    input  logic                        mem_ack,
    input  logic [7:0]                  mem_rdata
);

    localparam int unsigned AW = `INST_ADDR_WIDTH;
    localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] base_q;
    logic [1:0]    beat_q;
    logic [7:0]    tout_q;
    logic [23:0]   word_q;
    logic          err_q;
    logic          hit;
    logic          beat_ack;
    logic          last_beat;
    logic          timeout;

`ifdef BRIDGE_LAST_HIT_EN
    logic                        tag_valid_q;
    logic [AW-1:0]               tag_q;
    logic [`INST_DATA_WIDTH-1:0] hit_word_q;

    assign hit = tag_valid_q && (tag_q == (rom_addr_in & WORD_MASK));
`else
    assign hit = 1'b0;
`endif

    assign beat_ack  = (state == FETCH) && mem_ack;
    assign last_beat = beat_ack && (beat_q == 2'd3);
    // Abort on the 255th consecutive FETCH cycle without an ack.
    assign timeout   = (state == FETCH) && !mem_ack && (tout_q == TIMEOUT_LAST);

    assign mem_req     = (state == FETCH);
    assign fetch_stall = (state == FETCH);
    assign inst_valid  = (state == DONE);
    assign fetch_err   = (state == DONE) && err_q;
    assign mem_addr    = base_q | {{(AW-2){1'b0}}, beat_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rom_enable) state_nxt = hit ? DONE : FETCH;
            FETCH:   if (last_beat || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= '0;
            beat_q       <= '0;
            tout_q       <= '0;
            word_q       <= '0;
            err_q        <= 1'b0;
            rom_data_out <= '0;
`ifdef BRIDGE_LAST_HIT_EN
            tag_valid_q  <= 1'b0;
            tag_q        <= '0;
            hit_word_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rom_enable) begin
                        base_q <= rom_addr_in & WORD_MASK;
                        beat_q <= '0;
                        tout_q <= '0;
                        err_q  <= 1'b0;
`ifdef BRIDGE_LAST_HIT_EN
                        if (hit) rom_data_out <= hit_word_q;
`endif
                    end
                end
                FETCH: begin
                    if (beat_ack) begin
                        word_q <= {word_q[15:0], mem_rdata};
                        beat_q <= beat_q + 2'd1;
                        tout_q <= '0;
                        if (last_beat) begin
                            rom_data_out <= {word_q, mem_rdata};
`ifdef BRIDGE_LAST_HIT_EN
                            tag_valid_q <= 1'b1;
                            tag_q       <= base_q;
                            hit_word_q  <= {word_q, mem_rdata};
`endif
                        end
                    end else begin
                        tout_q <= tout_q + 8'd1;
                        if (timeout) begin
                            rom_data_out <= '0;
                            err_q        <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: byte-memory model with configurable ack delay,
// address and result scoreboards checked with immediate assertions.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_enable;
    logic [31:0] rom_addr_in;
    logic [31:0] rom_data_out;
    logic        inst_valid;
    logic        fetch_stall;
    logic        fetch_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    typedef struct {
        logic [31:0] word;
        logic        err;
        int          lat;
    } result_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr_q[$];
    result_t     res_q[$];
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    int          wait_cnt = 0;
    int          req_cycles = 0;

    always #5 clk = ~clk;

    inst_fetch_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_enable   (rom_enable),
        .rom_addr_in  (rom_addr_in),
        .rom_data_out (rom_data_out),
        .inst_valid   (inst_valid),
        .fetch_stall  (fetch_stall),
        .fetch_err    (fetch_err),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h4:   return 8'h34;
            32'h5:   return 8'h01;
            32'h6:   return 8'h00;
            32'h7:   return 8'h0A;
            default: return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: ack after ack_delay waiting cycles per beat.
    always_comb begin
        mem_ack   = mem_req && ack_en && (wait_cnt == ack_delay);
        mem_rdata = mem_byte(mem_addr);
    end

    always @(posedge clk) begin
        if (mem_req) req_cycles++;
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (mem_req && mem_ack) begin
            if (exp_addr_q.size() == 0) check("unexpected_beat", mem_addr, 32'hFFFF_FFFF);
            else                        check("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input int delay, input bit acks,
                            input bit hold_en, input int exp_lat, input logic [31:0] exp_word,
                            input bit exp_err, input string tag);
        result_t r;
        int      n;
        ack_delay = delay;
        ack_en    = acks;
        if (acks && exp_lat > 1)
            for (int i = 0; i < 4; i++) exp_addr_q.push_back({addr[31:2], 2'b00} + 32'(i));
        r.word = exp_word;
        r.err  = exp_err;
        r.lat  = exp_lat;
        res_q.push_back(r);
        @(negedge clk);
        rom_enable  = 1'b1;
        rom_addr_in = addr;
        @(posedge clk);
        #1;
        if (hold_en) rom_addr_in = ~addr;
        else         rom_enable  = 1'b0;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (inst_valid) break;
            check({tag, "_stall"}, {31'b0, fetch_stall}, 32'd1);
        end
        r = res_q.pop_front();
        check({tag, "_latency"}, 32'(n), 32'(r.lat));
        check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        check({tag, "_word"}, rom_data_out, r.word);
        check({tag, "_err"}, {31'b0, fetch_err}, {31'b0, r.err});
        check({tag, "_done_stall"}, {31'b0, fetch_stall}, 32'd0);
        @(negedge clk);
        if (hold_en) begin
            check({tag, "_no_accept_in_done"}, {31'b0, mem_req}, 32'd0);
            rom_enable = 1'b0;
        end
        check({tag, "_pulse"}, {31'b0, inst_valid}, 32'd0);
        check({tag, "_err_pulse"}, {31'b0, fetch_err}, 32'd0);
        check({tag, "_hold"}, rom_data_out, r.word);
        check({tag, "_beats_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        int req_before;
        rst_n       = 1'b0;
        rom_enable  = 1'b0;
        rom_addr_in = '0;
        #2;
        check("rst_data", rom_data_out, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_stall", {31'b0, fetch_stall}, 32'd0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_fetch(32'h0000_0004, 0, 1'b1, 1'b0, 5, 32'h3401_000A, 1'b0, "basic");
        do_fetch(32'h0000_0013, 0, 1'b1, 1'b1, 5, 32'hB5B4_B7B6, 1'b0, "unaligned");
        do_fetch(32'h0000_0020, 2, 1'b1, 1'b0, 13, 32'h8584_8786, 1'b0, "slow_ack");

        // Reset after two beats: fetch abandoned, no delivery.
        ack_delay = 0;
        ack_en    = 1'b1;
        exp_addr_q.push_back(32'h50);
        exp_addr_q.push_back(32'h51);
        @(negedge clk);
        rom_enable  = 1'b1;
        rom_addr_in = 32'h50;
        @(posedge clk);
        #1 rom_enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_req", {31'b0, mem_req}, 32'd0);
        check("midrst_stall", {31'b0, fetch_stall}, 32'd0);
        check("midrst_data", rom_data_out, 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_valid", {31'b0, inst_valid}, 32'd0);
        end
        rst_n = 1'b1;
        check("midrst_beats_left", 32'(exp_addr_q.size()), 32'd0);

        do_fetch(32'h0000_0040, 0, 1'b0, 1'b0, 256, 32'h0000_0000, 1'b1, "timeout");

        do_fetch(32'h0000_0004, 0, 1'b1, 1'b0, 5, 32'h3401_000A, 1'b0, "refill");
        req_before = req_cycles;
`ifdef BRIDGE_LAST_HIT_EN
        do_fetch(32'h0000_0006, 0, 1'b1, 1'b0, 1, 32'h3401_000A, 1'b0, "hit");
        check("hit_no_req", 32'(req_cycles - req_before), 32'd0);
`else
        do_fetch(32'h0000_0006, 0, 1'b1, 1'b0, 5, 32'h3401_000A, 1'b0, "repeat");
        check("repeat_req_cycles", 32'(req_cycles - req_before), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_bridge.md
INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

Interface
REQ-001 SHALL have parameter-free ports sized by `INST_ADDR_WIDTH` (32) and `INST_DATA_WIDTH` (32); one clock; reset asynchronous, active-low.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rom_enable  input  1  fetch request from core PC.
REQ-005 rom_addr_in  input  `INST_ADDR_WIDTH`  byte address of instruction to fetch.
REQ-006 rom_data_out  output  `INST_DATA_WIDTH`  assembled instruction word to core.
REQ-007 inst_valid  output  1  one-cycle pulse: rom_data_out updated this cycle.
REQ-008 fetch_stall  output  1  high while a fetch is outstanding.
REQ-009 fetch_err  output  1  one-cycle pulse with inst_valid when a fetch timed out.
REQ-010 mem_req  output  1  byte-read request to external byte-wide instruction memory.
REQ-011 mem_addr  output  `INST_ADDR_WIDTH`  byte address of current beat.
REQ-012 mem_ack  input  1  memory accepted beat; mem_rdata valid same cycle.
REQ-013 mem_rdata  input  8  read byte.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DONE.
REQ-015 IDLE: on rom_enable=1 (and no hit, REQ-030) SHALL latch base = {rom_addr_in[31:2], 2'b00}, clear beat counter, clear timeout counter, go to FETCH.
REQ-016 FETCH: mem_req=1, mem_addr = base + beat (beat 0..3); fetch_stall=1.
REQ-017 Beat completes on a rising edge with mem_req=1 and mem_ack=1; byte SHALL be stored big-endian: beat 0 -> [31:24], beat 3 -> [7:0]; beat increments.
REQ-018 mem_req SHALL stay high across beats; mem_addr SHALL advance the cycle after each ack.
REQ-019 On 4th ack SHALL go to DONE; mem_req deasserts in DONE.
REQ-020 DONE (exactly one cycle): rom_data_out = assembled word, inst_valid=1, fetch_stall=0; next state IDLE.
REQ-021 Minimum fetch latency: 4 cycles FETCH + 1 cycle DONE = 5 cycles from IDLE acceptance to inst_valid.
REQ-022 rom_addr_in and rom_enable changes during FETCH SHALL be ignored; the latched fetch completes and is delivered.
REQ-023 rom_enable=1 in DONE SHALL NOT start a fetch that cycle; acceptance only in IDLE.
REQ-024 Timeout: 8-bit counter increments each FETCH cycle without ack, clears on ack; at count 255 SHALL abort to DONE with rom_data_out=32'h0000_0000 (NOP) and fetch_err=1.
REQ-025 rom_data_out SHALL hold its last value outside DONE.
REQ-026 Beat counter wraps only via FSM exit; base+beat SHALL not carry beyond bit 1.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, rom_data_out=0, inst_valid=0, fetch_stall=0, fetch_err=0, mem_req=0, mem_addr=0, counters=0, last-hit tag invalid.
REQ-028 Reset mid-FETCH SHALL abandon the fetch with no inst_valid pulse; memory sees mem_req drop asynchronously.
REQ-029 After rst_n release, first acceptance SHALL occur no earlier than the first rising edge.

Configuration
REQ-030 Macro BRIDGE_LAST_HIT_EN defined: bridge SHALL keep tag of last successfully fetched base (not timed-out); in IDLE, rom_enable=1 with matching base SHALL skip FETCH, go to DONE next cycle, and return the stored word (latency 1, no mem_req).
REQ-031 Macro undefined: no tag storage; every request performs 4 memory beats.

Verification
REQ-032 Reset release, rom_enable=1, addr=0x0000_0004, mem_ack always 1, bytes 0x34,0x01,0x00,0x0A -> mem_addr 4,5,6,7; inst_valid 5 cycles after acceptance; rom_data_out=0x3401000A.
REQ-033 Unaligned addr 0x0000_0013 -> mem_addr sequence 0x10..0x13.
REQ-034 mem_ack withheld 2 cycles per beat -> inst_valid 13 cycles after acceptance, fetch_stall high throughout FETCH.
REQ-035 mem_ack never asserted -> after 255 FETCH cycles, inst_valid=1, fetch_err=1, rom_data_out=0x00000000.
REQ-036 rst_n pulsed low after beat 2 -> mem_req=0 immediately, no inst_valid, rom_data_out=0.
REQ-037 BRIDGE_LAST_HIT_EN defined, repeat fetch of 0x0000_0004 -> no mem_req, inst_valid 1 cycle after acceptance, rom_data_out=0x3401000A.
